// File: rtl/display_sched_pkg.sv
// Shared types and constants for the display page scheduler.
package display_sched_pkg;

   typedef enum logic [1:0] {
      ROTATE = 2'd0,
      HOLD   = 2'd1,
      FLASH  = 2'd2,
      HALT   = 2'd3
   } sched_state_e;

   localparam logic [1:0] PAGE_LIVE   = 2'd0;
   localparam logic [1:0] PAGE_TRADE  = 2'd1;
   localparam logic [1:0] PAGE_STATUS = 2'd2;

   localparam logic [7:0] SAT_MAX        = 8'd99;
   localparam logic [7:0] TRADE_PAGE_TAG = 8'd1;

   // One 2-digit slot per display pair
   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] c;
   } slot_set_t;

   function automatic logic [7:0] sat8(input logic [7:0] v);
      return (v > SAT_MAX) ? SAT_MAX : v;
   endfunction

   // Page rotation order LIVE -> TRADE -> STATUS -> LIVE
   function automatic logic [1:0] next_page(input logic [1:0] p);
      return (p == PAGE_STATUS) ? PAGE_LIVE : 2'(p + 2'd1);
   endfunction

endpackage

// File: rtl/display_page_scheduler_tick_counter.sv
// Terminal-count counter: counts 0..N-1 while en, wraps at N-1, clr wins over en.
module tick_counter #(
   parameter int unsigned N = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tc
);

   localparam int unsigned W = $clog2(N);
   localparam logic [W-1:0] LAST = W'(N - 1);

   logic [W-1:0] cnt_q, cnt_d;

   // tc depends only on en and the count so callers may use it next to clr
   assign tc = en && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == LAST) ? '0 : W'(cnt_q + W'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/display_page_scheduler.sv
// Chooses which engine status page drives the three HEX slot pairs.
// Build option MATCH_FLASH_EN: a trade match temporarily forces the TRADE page.
module display_page_scheduler
   import display_sched_pkg::*;
#(
   parameter int unsigned DWELL_CYCLES   = 50_000_000,
   parameter int unsigned REFRESH_CYCLES = 5_000_000,
   parameter int unsigned FLASH_CYCLES   = 100_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] buy_price,
   input  logic [7:0] sell_price,
   input  logic [7:0] spread_now,
   input  logic [7:0] last_trade_price,
   input  logic [7:0] trade_count,
   input  logic [1:0] engine_state,
   input  logic [7:0] halt_code,
   input  logic       halt_signal,
   input  logic       match_signal,
   input  logic       btn_next,
   input  logic       btn_hold,
   output logic [7:0] slot_a,
   output logic [7:0] slot_b,
   output logic [7:0] slot_c,
   output logic [1:0] page_sel,
   output logic       slot_update,
   output logic       sat_flag,
   output logic       hold_active
);

   sched_state_e state_q, state_d;
   logic [1:0]   page_q, page_d;
   logic         page_chg_q, page_chg_d;
   logic         btn_next_q, btn_next_d;
   logic         btn_hold_q, btn_hold_d;
   slot_set_t    slots_q, slots_d, raw_c;
   logic         slot_update_q, slot_update_d;
   logic         sat_flag_q, sat_flag_d;
   logic         hold_active_q, hold_active_d;

   logic next_edge_c, hold_edge_c, load_c;
   logic dwell_en_c, dwell_clr, dwell_tc, refresh_tc;

   assign next_edge_c = btn_next & ~btn_next_q;
   assign hold_edge_c = btn_hold & ~btn_hold_q;
   assign dwell_en_c  = (state_q == ROTATE);

   tick_counter #(.N(DWELL_CYCLES)) u_dwell (
      .clk(clk), .reset(reset), .en(dwell_en_c), .clr(dwell_clr), .tc(dwell_tc)
   );

   tick_counter #(.N(REFRESH_CYCLES)) u_refresh (
      .clk(clk), .reset(reset), .en(1'b1), .clr(page_chg_q), .tc(refresh_tc)
   );

`ifdef MATCH_FLASH_EN
   sched_state_e saved_state_q, saved_state_d, ret_state;
   logic [1:0]   saved_page_q, saved_page_d;
   logic         flash_en_c, flash_clr, flash_tc;

   assign flash_en_c = (state_q == FLASH);

   tick_counter #(.N(FLASH_CYCLES)) u_flash (
      .clk(clk), .reset(reset), .en(flash_en_c), .clr(flash_clr), .tc(flash_tc)
   );
`else
   logic unused_match;
   localparam int unsigned unused_flash_cycles = FLASH_CYCLES;
   assign unused_match = match_signal;
`endif

   // Page/state selection: halt > match > btn_next > dwell expiry > btn_hold
   always_comb begin
      state_d    = state_q;
      page_d     = page_q;
      dwell_clr  = 1'b0;
      btn_next_d = btn_next;
      btn_hold_d = btn_hold;
`ifdef MATCH_FLASH_EN
      saved_state_d = saved_state_q;
      saved_page_d  = saved_page_q;
      flash_clr     = 1'b0;
      ret_state     = saved_state_q;
`endif
      if (halt_signal) begin
         state_d   = HALT;
         page_d    = PAGE_STATUS;
         dwell_clr = 1'b1;
`ifdef MATCH_FLASH_EN
         flash_clr = 1'b1;
`endif
      end else begin
         case (state_q)
            HALT: begin
               state_d   = ROTATE;
               page_d    = PAGE_LIVE;
               dwell_clr = 1'b1;
            end
            ROTATE, HOLD: begin
`ifdef MATCH_FLASH_EN
               if (match_signal) begin
                  saved_state_d = state_q;
                  saved_page_d  = page_q;
                  state_d       = FLASH;
                  page_d        = PAGE_TRADE;
                  flash_clr     = 1'b1;
                  dwell_clr     = 1'b1;
               end else
`endif
               begin
                  // btn_next and dwell expiry together advance a single page
                  if (next_edge_c) begin
                     page_d    = next_page(page_q);
                     dwell_clr = 1'b1;
                  end else if (dwell_tc) begin
                     page_d = next_page(page_q);
                  end
                  if (hold_edge_c) begin
                     if (state_q == ROTATE) begin
                        state_d = HOLD;
                     end else begin
                        state_d   = ROTATE;
                        dwell_clr = 1'b1;
                     end
                  end
               end
            end
`ifdef MATCH_FLASH_EN
            FLASH: begin
               if (hold_edge_c) begin
                  ret_state = (saved_state_q == HOLD) ? ROTATE : HOLD;
               end
               saved_state_d = ret_state;
               if (match_signal) begin
                  flash_clr = 1'b1;
               end else if (flash_tc) begin
                  state_d   = ret_state;
                  page_d    = saved_page_q;
                  dwell_clr = 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end

      page_chg_d = (page_d != page_q);
`ifdef MATCH_FLASH_EN
      hold_active_d = (state_d == HOLD) || ((state_d == FLASH) && (saved_state_d == HOLD));
`else
      hold_active_d = (state_d == HOLD);
`endif
   end

   // Slot snapshot with saturation; loads on refresh expiry or right after a page change
   always_comb begin
      raw_c = '0;
      case (page_q)
         PAGE_LIVE: begin
            raw_c.a = buy_price;
            raw_c.b = sell_price;
            raw_c.c = spread_now;
         end
         PAGE_TRADE: begin
            raw_c.a = last_trade_price;
            raw_c.b = trade_count;
            raw_c.c = TRADE_PAGE_TAG;
         end
         PAGE_STATUS: begin
            raw_c.a = halt_code;
            raw_c.b = {6'b0, engine_state};
            raw_c.c = trade_count;
         end
         default: raw_c = '0;
      endcase

      load_c        = page_chg_q | refresh_tc;
      slots_d       = slots_q;
      sat_flag_d    = sat_flag_q;
      slot_update_d = load_c;
      if (load_c) begin
         slots_d.a  = sat8(raw_c.a);
         slots_d.b  = sat8(raw_c.b);
         slots_d.c  = sat8(raw_c.c);
         sat_flag_d = (raw_c.a > SAT_MAX) | (raw_c.b > SAT_MAX) | (raw_c.c > SAT_MAX);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ROTATE;
         page_q        <= PAGE_LIVE;
         page_chg_q    <= 1'b0;
         btn_next_q    <= 1'b0;
         btn_hold_q    <= 1'b0;
         slots_q       <= '0;
         slot_update_q <= 1'b0;
         sat_flag_q    <= 1'b0;
         hold_active_q <= 1'b0;
`ifdef MATCH_FLASH_EN
         saved_state_q <= ROTATE;
         saved_page_q  <= PAGE_LIVE;
`endif
      end else begin
         state_q       <= state_d;
         page_q        <= page_d;
         page_chg_q    <= page_chg_d;
         btn_next_q    <= btn_next_d;
         btn_hold_q    <= btn_hold_d;
         slots_q       <= slots_d;
         slot_update_q <= slot_update_d;
         sat_flag_q    <= sat_flag_d;
         hold_active_q <= hold_active_d;
`ifdef MATCH_FLASH_EN
         saved_state_q <= saved_state_d;
         saved_page_q  <= saved_page_d;
`endif
      end
   end

   assign slot_a      = slots_q.a;
   assign slot_b      = slots_q.b;
   assign slot_c      = slots_q.c;
   assign page_sel    = page_q;
   assign slot_update = slot_update_q;
   assign sat_flag    = sat_flag_q;
   assign hold_active = hold_active_q;

endmodule
